pipe_skid_reg: RTL
==================

Name: pipe_skid_reg

Overview:
- Parametrised successor to the fixed-width IF/ID, ID/EX, EX/MEM and MEM/WB pipeline latches.
- Carries an arbitrary-width stage bundle and adds a valid/ready handshake, a 2-entry skid buffer, synchronous flush-to-bubble and a saturating stall counter.
- Sits between any two pipeline stages, so back-pressure from a later stage does not combinationally reach earlier stages.

Parameters:
- WIDTH, 107, bundle width in bits; bit order is [0:WIDTH-1], bit 0 is MSB.
- BUBBLE, {WIDTH{1'b0}}, data value loaded on reset and flush, and present whenever out_valid=0.
- SKID, 1; 1 = 2-entry skid mode with registered in_ready; 0 = single-entry mode with combinational in_ready.
- CNTW, 16, stall counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash of all held entries.
- in_data  in  [0:WIDTH-1]  bundle from the upstream stage.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry this cycle.
- out_data  out  [0:WIDTH-1]  bundle to the downstream stage, taken from the main register.
- out_valid  out  1  main register holds a valid entry.
- out_ready  in  1  downstream accepts the entry this cycle.
- occ  out  [0:1]  occupancy: 0, 1 or 2.
- stall_cnt  out  [0:CNTW-1]  saturating count of stall cycles.

Behaviour:
- Definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Reset (asynchronous):
  - state=EMPTY; main and skid registers = BUBBLE.
  - out_valid=0, occ=0, stall_cnt=0.
  - in_ready=1 when SKID=1.
- States: EMPTY (occ 0), ONE (main full, occ 1), TWO (main and skid full, occ 2; SKID=1 only).
- Transitions when flush=0:
  - EMPTY, in_fire: main<=in_data, go to ONE.
  - ONE, in_fire & out_fire: main<=in_data, stay in ONE.
  - ONE, in_fire & !out_fire: skid<=in_data, go to TWO.
  - ONE, !in_fire & out_fire: main<=BUBBLE, go to EMPTY.
  - TWO, out_fire: main<=skid, skid<=BUBBLE, go to ONE.
  - TWO: in_ready=0, so no capture can occur.
- in_ready:
  - SKID=1: registered; in_ready = (next state != TWO). It has no combinational path from out_ready.
  - SKID=0: in_ready = !out_valid | out_ready (combinational). State TWO is unreachable.
- Latency and throughput:
  - One cycle from in_fire to out_valid in both modes.
  - Full throughput of 1 entry per cycle while out_ready=1.
- Ordering: strict FIFO. No entry is duplicated or lost except by flush.
- Flush (highest priority after reset):
  - Next state=EMPTY; main and skid registers = BUBBLE.
  - Any in_fire in the same cycle is dropped.
  - An out_fire in the same cycle still counts as delivered downstream; the downstream stage decides whether to honour it.
  - in_ready=1 in the following cycle.
- stall_cnt:
  - Increments by 1 in every cycle with out_valid & !out_ready.
  - Saturates at 2^CNTW-1; no wrap.
  - Cleared only by reset; flush does not clear it.
- Data stability: out_data and out_valid do not change while out_valid=1 & out_ready=0, unless flush=1.
- Invariant: out_data==BUBBLE whenever out_valid=0.
- Reset mid-transfer: all entries are discarded immediately; outputs take their reset values asynchronously.

Decomposition:
- Shared package (pipe_pkg):
  - State encodings EMPTY=2'b00, ONE=2'b01, TWO=2'b11.
  - Default WIDTH constants for each stage bundle (IF_ID_W, ID_EX_W, EX_MEM_W, MEM_WB_W=107).
- One sub-module, pipe_stall_counter: parametrised CNTW, saturating increment, asynchronous reset. It is reused by other stage monitors.
- Field slicing of the bundle (e.g. nextPC, destReg, RegWrite) stays in each stage wrapper, not in this block.

Test Plan:
- Reset, then in_valid=1, in_data=0x...0001, out_ready=1 for 4 cycles with data incrementing -> out_valid rises 1 cycle later; out_data sequence 1,2,3,4 back-to-back; occ=1; stall_cnt=0.
- SKID=1, out_ready=0 while sending 3 entries A, B, C -> A and B accepted, occ=2, in_ready=0 on the cycle after B, C held upstream, out_data=A stable, stall_cnt counts 1,2,3... Then out_ready=1 -> output sequence A, B, C with no gaps and no loss.
- flush=1 while occ=2 with in_valid=1 -> next cycle occ=0, out_valid=0, out_data=BUBBLE, in_ready=1; the input presented in the flush cycle never appears at the output.
- CNTW=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt saturates at 15 and holds; a later flush leaves it at 15; reset returns it to 0.
- SKID=0, out_ready toggling 1,0,1,0 with continuous input -> in_ready mirrors the condition !out_valid|out_ready in the same cycle; occ never exceeds 1; order preserved.
- Assert reset asynchronously mid-cycle with occ=2 -> out_valid=0, occ=0 and out_data=BUBBLE before the next clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: FSM state encoding
// and the default bundle width of each classic stage boundary.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } pipe_state_e;

    localparam int IF_ID_W  = 64;
    localparam int ID_EX_W  = 150;
    localparam int EX_MEM_W = 107;
    localparam int MEM_WB_W = 107;

    function automatic logic [1:0] occ_of(input pipe_state_e st);
        case (st)
            ONE:     return 2'd1;
            TWO:     return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stall_counter.sv
// Saturating event counter; shared with the other stage monitors.
module pipe_stall_counter #(
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inc,
    output logic [CNTW-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {CNTW{1'b1}})) begin
            count <= count + CNTW'(1);
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Generic pipeline stage register with valid/ready handshake, optional
// 2-entry skid buffer, flush-to-bubble and a saturating stall counter.
//
//   state | meaning
//   EMPTY | nothing held, out_valid=0, main=BUBBLE
//   ONE   | main holds the oldest entry, skid=BUBBLE
//   TWO   | main and skid both full (skid mode only), in_ready=0
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH  = MEM_WB_W,
    parameter logic [0:WIDTH-1] BUBBLE = {WIDTH{1'b0}},
    parameter bit               SKID   = 1'b1,
    parameter int               CNTW   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [0:WIDTH-1] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [0:WIDTH-1] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:1]       occ,
    output logic [0:CNTW-1]  stall_cnt
);

    pipe_state_e      state, state_nxt;
    logic [0:WIDTH-1] main_q, main_nxt;
    logic [0:WIDTH-1] skid_q, skid_nxt;
    logic             in_fire;
    logic             out_fire;

    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign occ       = occ_of(state);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (flush) begin
            state_nxt = EMPTY;
            main_nxt  = BUBBLE;
            skid_nxt  = BUBBLE;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_nxt  = in_data;
                        state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_nxt = in_data;
                    end else if (in_fire) begin
                        skid_nxt  = in_data;
                        state_nxt = TWO;
                    end else if (out_fire) begin
                        main_nxt  = BUBBLE;
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        main_nxt  = skid_q;
                        skid_nxt  = BUBBLE;
                        state_nxt = ONE;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                    main_nxt  = BUBBLE;
                    skid_nxt  = BUBBLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= EMPTY;
            main_q <= BUBBLE;
            skid_q <= BUBBLE;
        end else begin
            state  <= state_nxt;
            main_q <= main_nxt;
            skid_q <= skid_nxt;
        end
    end

    // Skid mode registers in_ready so out_ready never reaches upstream combinationally.
    if (SKID) begin : g_skid
        logic in_ready_q;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                in_ready_q <= 1'b1;
            end else begin
                in_ready_q <= (state_nxt != TWO);
            end
        end
        assign in_ready = in_ready_q;
    end else begin : g_single
        assign in_ready = !out_valid || out_ready;
    end

    pipe_stall_counter #(
        .CNTW (CNTW)
    ) u_stall_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (out_valid && !out_ready),
        .count (stall_cnt)
    );

endmodule
